// File: rtl/fx2_in_writer.sv
// FX2LP slave-FIFO IN writer: moves a valid/ready word stream onto fd/slwr_n,
// honours ff_n and commits short packets with pktend_n on flush or idle timeout.
module fx2_in_writer #(
    parameter int unsigned PKT_WORDS = 256,
    parameter int unsigned TIMEOUT   = 64,
    parameter bit          ZLP_EN    = 1'b0,
    parameter logic [1:0]  FIFOADR   = 2'b10
) (
    input  logic        ifclk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ff_n,
    output logic [15:0] fd_out,
    output logic        fd_oe,
    output logic        slwr_n,
    output logic        slrd_n,
    output logic        sloe_n,
    output logic        pktend_n,
    output logic [1:0]  fifoadr,
    output logic        busy
);

    localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] CNT_LAST  = WW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, PKTEND} state_t;

    state_t         state, state_nxt;
    logic [15:0]    buf_mem [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     occ;
    logic [WW-1:0]  word_cnt;
    logic [IW-1:0]  idle_cnt;
    logic           flush_pend;
    logic           push, do_write, do_pktend, do_drop;
    logic           idle_tick, timeout_hit;

    assign in_ready = (occ != 2'd2) && !rst;
    assign push     = in_valid && in_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = IDLE;
        do_write  = 1'b0;
        do_pktend = 1'b0;
        do_drop   = 1'b0;
        if (state != PKTEND) begin
            if (occ != 2'd0 && ff_n) begin
                do_write  = 1'b1;
                state_nxt = WRITE;
            end else if (flush_pend && occ == 2'd0) begin
                if (word_cnt != '0 || ZLP_EN) begin
                    // Commit waits for room in the FX2 FIFO.
                    if (ff_n) begin
                        do_pktend = 1'b1;
                        state_nxt = PKTEND;
                    end
                end else begin
                    do_drop = 1'b1;
                end
            end
        end
    end

    assign idle_tick   = (occ == 2'd0) && (word_cnt != '0);
    assign timeout_hit = (TIMEOUT != 0) && idle_tick && (idle_cnt == IDLE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ifclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the two data slots are not reset; occupancy alone says which hold valid words.
    always_ff @(posedge ifclk) begin
        if (push) buf_mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge ifclk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push)     wr_ptr <= ~wr_ptr;
            if (do_write) rd_ptr <= ~rd_ptr;
            case ({push, do_write})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge ifclk) begin
        if (rst) begin
            fd_out     <= 16'h0000;
            fd_oe      <= 1'b0;
            slwr_n     <= 1'b1;
            pktend_n   <= 1'b1;
            word_cnt   <= '0;
            idle_cnt   <= '0;
            flush_pend <= 1'b0;
        end else begin
            fd_oe    <= 1'b1;
            slwr_n   <= !do_write;
            pktend_n <= !do_pktend;

            // Wrap to zero is the FX2 AUTOIN commit; no pktend needed there.
            if (do_write) begin
                fd_out   <= buf_mem[rd_ptr];
                word_cnt <= (word_cnt == CNT_LAST) ? '0 : word_cnt + 1'b1;
            end else if (do_pktend) begin
                word_cnt <= '0;
            end

            if (do_write || do_pktend)
                idle_cnt <= '0;
            else if (idle_tick && idle_cnt != IDLE_LAST)
                idle_cnt <= idle_cnt + 1'b1;

            // A flush arriving while the pktend goes out is absorbed.
            if (do_pktend || do_drop)
                flush_pend <= 1'b0;
            else if ((flush && state != PKTEND) || timeout_hit)
                flush_pend <= 1'b1;
        end
    end

    assign busy    = (occ != 2'd0) || flush_pend || (word_cnt != '0);
    assign slrd_n  = 1'b1;
    assign sloe_n  = 1'b1;
    assign fifoadr = FIFOADR;

endmodule

// File: tb/tb_fx2_in_writer.sv
// Bench for fx2_in_writer: scoreboard of pushed words and packet commits checked
// every cycle, plus directed scenarios with hand-computed counts.
module tb_fx2_in_writer;

    localparam int PKT = 256;
    localparam int TMO = 64;

    logic        ifclk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        ff_n = 1'b1;
    logic        in_ready, fd_oe, slwr_n, slrd_n, sloe_n, pktend_n, busy;
    logic [15:0] fd_out;
    logic [1:0]  fifoadr;

    logic        z_flush = 1'b0;
    logic [15:0] z_in_data = 16'h0000;
    logic        z_in_valid = 1'b0;
    logic        z_in_ready, z_fd_oe, z_slwr_n, z_slrd_n, z_sloe_n, z_pktend_n, z_busy;
    logic [15:0] z_fd_out;
    logic [1:0]  z_fifoadr;

    fx2_in_writer #(.PKT_WORDS(PKT), .TIMEOUT(TMO), .ZLP_EN(1'b0), .FIFOADR(2'b10)) dut (
        .ifclk(ifclk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ff_n(ff_n), .fd_out(fd_out), .fd_oe(fd_oe), .slwr_n(slwr_n),
        .slrd_n(slrd_n), .sloe_n(sloe_n), .pktend_n(pktend_n), .fifoadr(fifoadr), .busy(busy)
    );

    fx2_in_writer #(.PKT_WORDS(PKT), .TIMEOUT(0), .ZLP_EN(1'b1), .FIFOADR(2'b10)) dut_zlp (
        .ifclk(ifclk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .flush(z_flush), .ff_n(1'b1), .fd_out(z_fd_out), .fd_oe(z_fd_oe), .slwr_n(z_slwr_n),
        .slrd_n(z_slrd_n), .sloe_n(z_sloe_n), .pktend_n(z_pktend_n), .fifoadr(z_fifoadr), .busy(z_busy)
    );

    always #5 ifclk = ~ifclk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: words accepted but not yet on the bus, words sent since the last commit.
    logic [15:0] exp_q [$];
    int          pend_words = 0;
    bit          flush_seen = 0;
    int          gap = 0;
    int          n_writes = 0;
    int          n_pktends = 0;
    int          last_pk_gap = 0;
    bit          push_d = 0;
    logic [15:0] push_data_d = 16'h0000;
    bit          flush_d = 0;
    bit          ff_d = 1;
    bit          rst_d = 1;
    bit          pk_d = 0;

    always @(negedge ifclk) begin
        check("slrd_n", 32'(slrd_n), 1);
        check("sloe_n", 32'(sloe_n), 1);
        check("fifoadr", 32'(fifoadr), 2);
        if (rst_d) begin
            check("rst_slwr_n", 32'(slwr_n), 1);
            check("rst_pktend_n", 32'(pktend_n), 1);
            check("rst_fd_out", 32'(fd_out), 0);
            check("rst_fd_oe", 32'(fd_oe), 0);
            check("rst_busy", 32'(busy), 0);
            exp_q.delete();
            pend_words = 0;
            flush_seen = 0;
            gap = 0;
            pk_d = 0;
        end else begin
            if (push_d) exp_q.push_back(push_data_d);
            if (flush_d && !pk_d) flush_seen = 1;
            check("fd_oe", 32'(fd_oe), 1);
            gap++;
            if (slwr_n == 1'b0) begin
                check("write_while_full", 32'(ff_d), 1);
                check("spurious_write", 32'(exp_q.size() == 0), 0);
                if (exp_q.size() != 0) begin
                    check("fd_out_order", 32'(fd_out), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                pend_words = (pend_words + 1) % PKT;
                gap = 0;
                n_writes++;
            end
            if (pktend_n == 1'b0) begin
                check("pktend_slwr_n", 32'(slwr_n), 1);
                check("pktend_while_full", 32'(ff_d), 1);
                check("pktend_empty_packet", 32'(pend_words == 0), 0);
                check("pktend_width", 32'(pk_d), 0);
                if (!flush_seen) check("timeout_gap", 32'(gap), 32'(TMO + 1));
                last_pk_gap = gap;
                pend_words = 0;
                flush_seen = 0;
                gap = 0;
                n_pktends++;
            end
            if (exp_q.size() == 0 && pend_words == 0) flush_seen = 0;
            pk_d = (pktend_n == 1'b0);
        end
        check("in_ready", 32'(in_ready), 32'(!rst && exp_q.size() < 2));
        push_d      = in_valid && in_ready;
        push_data_d = in_data;
        flush_d     = flush;
        ff_d        = ff_n;
        rst_d       = rst;
    end

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, input logic fl);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_accept", 32'(in_ready), 1);
        flush = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("settle_busy", 32'(busy), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w0, p0, zc, zw, n;

        repeat (3) tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_slwr_n", 32'(slwr_n), 1);
        check("reset_fd_oe", 32'(fd_oe), 0);
        rst = 1'b0;
        tick();
        check("fd_oe_after_reset", 32'(fd_oe), 1);

        // Four words, no stall, no commit until the idle timeout.
        w0 = n_writes; p0 = n_pktends;
        for (int i = 1; i <= 4; i++) push_word(16'(i), 1'b0);
        repeat (3) tick();
        check("t1_writes", 32'(n_writes - w0), 4);
        check("t1_no_pktend", 32'(n_pktends - p0), 0);
        check("t1_last_fd", 32'(fd_out), 32'h0004);
        check("t1_busy", 32'(busy), 1);
        settle();
        check("t1_timeout_commit", 32'(n_pktends - p0), 1);

        // Back-pressure from ff_n mid-stream.
        w0 = n_writes; p0 = n_pktends;
        push_word(16'h0030, 1'b0);
        push_word(16'h0031, 1'b0);
        ff_n = 1'b0;
        push_word(16'h0032, 1'b0);
        repeat (10) tick();
        check("t3_stalled_writes", 32'(n_writes - w0), 1);
        check("t3_in_ready_low", 32'(in_ready), 0);
        check("t3_slwr_n_high", 32'(slwr_n), 1);
        ff_n = 1'b1;
        push_word(16'h0033, 1'b0);
        push_word(16'h0034, 1'b0);
        repeat (4) tick();
        check("t3_writes", 32'(n_writes - w0), 5);
        check("t3_last_fd", 32'(fd_out), 32'h0034);
        settle();
        check("t3_commit", 32'(n_pktends - p0), 1);

        // Flush together with the fifth word.
        w0 = n_writes; p0 = n_pktends;
        for (int i = 0; i < 5; i++) push_word(16'(16'h0040 + i), (i == 4));
        repeat (4) tick();
        check("t4_writes", 32'(n_writes - w0), 5);
        check("t4_pktends", 32'(n_pktends - p0), 1);
        check("t4_pktend_follows_last", 32'(last_pk_gap), 1);
        check("t4_busy", 32'(busy), 0);

        // Flush with nothing pending: silent without ZLP, one zero-length pktend with it.
        p0 = n_pktends;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        check("t5_no_pktend", 32'(n_pktends - p0), 0);
        check("t5_busy", 32'(busy), 0);
        zc = 0; zw = 0;
        z_flush = 1'b1;
        tick();
        z_flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!z_pktend_n) zc++;
            if (!z_slwr_n) zw++;
        end
        check("t5_zlp_count", 32'(zc), 1);
        check("t5_zlp_no_write", 32'(zw), 0);
        check("t5_zlp_busy", 32'(z_busy), 0);
        check("t5_zlp_fd_out", 32'(z_fd_out), 0);
        check("t5_zlp_in_ready", 32'(z_in_ready), 1);
        check("t5_zlp_consts", 32'({z_fd_oe, z_slrd_n, z_sloe_n, z_fifoadr}), 32'b11110);

        // Commit held off while the FX2 FIFO is full.
        w0 = n_writes; p0 = n_pktends;
        push_word(16'h0070, 1'b0);
        push_word(16'h0071, 1'b0);
        repeat (2) tick();
        ff_n = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check("t7_pktend_held", 32'(n_pktends - p0), 0);
        check("t7_pktend_n_high", 32'(pktend_n), 1);
        ff_n = 1'b1;
        repeat (3) tick();
        check("t7_pktend_released", 32'(n_pktends - p0), 1);
        check("t7_writes", 32'(n_writes - w0), 2);
        check("t7_busy", 32'(busy), 0);

        // Reset mid-packet with two words still buffered.
        w0 = n_writes; p0 = n_pktends;
        for (int i = 0; i < 3; i++) push_word(16'(16'h0060 + i), 1'b0);
        repeat (2) tick();
        check("t6_written_before_reset", 32'(n_writes - w0), 3);
        ff_n = 1'b0;
        push_word(16'h0063, 1'b0);
        push_word(16'h0064, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_slwr_n", 32'(slwr_n), 1);
        check("t6_pktend_n", 32'(pktend_n), 1);
        check("t6_fd_out", 32'(fd_out), 0);
        check("t6_fd_oe", 32'(fd_oe), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        ff_n = 1'b1;
        repeat (80) tick();
        check("t6_no_pktend", 32'(n_pktends - p0), 0);
        check("t6_no_stale_write", 32'(n_writes - w0), 3);

        // Fresh stream of exactly one packet plus flush: AUTOIN commit, no pktend.
        w0 = n_writes; p0 = n_pktends;
        for (int i = 0; i < PKT; i++) push_word(16'(16'h1000 + i), (i == PKT - 1));
        repeat (4) tick();
        check("t6_wrap_writes", 32'(n_writes - w0), 256);
        check("t6_wrap_no_pktend", 32'(n_pktends - p0), 0);
        check("t6_wrap_busy", 32'(busy), 0);

        // One packet plus three words, then a timeout commit of the tail.
        w0 = n_writes; p0 = n_pktends;
        for (int i = 0; i < PKT + 3; i++) push_word(16'(16'h2000 + i), 1'b0);
        n = 0;
        while (n_pktends == p0 && n < 200) begin
            tick();
            n++;
        end
        check("t2_pktends", 32'(n_pktends - p0), 1);
        check("t2_timeout_gap", 32'(last_pk_gap), 65);
        check("t2_writes", 32'(n_writes - w0), 259);
        check("t2_last_fd", 32'(fd_out), 32'h2102);
        tick();
        check("t2_busy", 32'(busy), 0);
        check("t2_pktend_n", 32'(pktend_n), 1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
